// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instruction requests and writes them to instruction memory from BASE_ADDR upward; 1-cycle latency, 1 word/cycle.
// req_ready is low outside LOAD, during start, and once IMEM_DEPTH words are pending.
module instr_encoder_loader #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] BASE_ADDR  = RESET_PC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        finish,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_kind,
    input  logic [2:0]                  req_alu,
    input  logic [4:0]                  req_rd,
    input  logic [4:0]                  req_rs1,
    input  logic [4:0]                  req_rs2,
    input  logic [31:0]                 req_imm,
    output logic                        imem_we,
    output logic [XLEN-1:0]             imem_addr,
    output logic [31:0]                 imem_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  err_code,
    output logic [$clog2(IMEM_DEPTH):0] count
);

    localparam int CW = $clog2(IMEM_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CW = CW'(IMEM_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [2:0] K_R    = 3'd0;
    localparam logic [2:0] K_I    = 3'd1;
    localparam logic [2:0] K_LW   = 3'd2;
    localparam logic [2:0] K_SW   = 3'd3;
    localparam logic [2:0] K_BEQ  = 3'd4;
    localparam logic [2:0] K_JAL  = 3'd5;
    localparam logic [2:0] K_NOP  = 3'd6;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [2:0]  F3_WORD  = 3'b010;
    localparam logic [2:0]  F3_BEQ   = 3'b000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [31:0]     dat;
    } wr_t;

    logic [2:0]    state;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] wr_cnt;
    logic          wr_vld;
    wr_t           wr_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    logic          full;
    logic          fire;
    logic          chk;
    logic          wr_en;
    logic          new_err;
    logic [1:0]    chk_code;
    logic [2:0]    alu_f3;
    logic          alu_legal;
    logic          kind_bad;
    logic          imm_bad;
    logic [31:0]   enc;
    logic          imm12_ok;
    logic          beq_ok;
    logic          jal_ok;

    assign full      = (wr_ptr == DEPTH_CW);
    assign req_ready = (state == S_LOAD) && !start && !full;
    assign fire      = req_valid && req_ready;
    // Requests are screened whenever offered in LOAD, even when full, so overflow can be flagged.
    assign chk       = req_valid && (state == S_LOAD) && !start;

    // Range checks as sign-extension tests on the upper immediate bits.
    assign imm12_ok = (req_imm[31:11] == '0) || (req_imm[31:11] == '1);
    assign beq_ok   = ((req_imm[31:12] == '0) || (req_imm[31:12] == '1)) && !req_imm[0];
    assign jal_ok   = ((req_imm[31:20] == '0) || (req_imm[31:20] == '1)) && !req_imm[0];

    always_comb begin
        alu_f3    = 3'b000;
        alu_legal = 1'b1;
        case (req_alu)
            ALU_ADD, ALU_SUB: alu_f3 = 3'b000;
            ALU_AND:          alu_f3 = 3'b111;
            ALU_OR:           alu_f3 = 3'b110;
            ALU_SLT:          alu_f3 = 3'b010;
            default:          alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        enc      = '0;
        kind_bad = 1'b0;
        imm_bad  = 1'b0;
        case (req_kind)
            K_R: begin
                kind_bad = !alu_legal;
                enc = {(req_alu == ALU_SUB) ? 7'h20 : 7'h00, req_rs2, req_rs1, alu_f3, req_rd, OP_R};
            end
            K_I: begin
                kind_bad = !alu_legal || (req_alu == ALU_SUB);
                imm_bad  = !imm12_ok;
                enc = {req_imm[11:0], req_rs1, alu_f3, req_rd, OP_I};
            end
            K_LW: begin
                imm_bad = !imm12_ok;
                enc = {req_imm[11:0], req_rs1, F3_WORD, req_rd, OP_LW};
            end
            K_SW: begin
                imm_bad = !imm12_ok;
                enc = {req_imm[11:5], req_rs2, req_rs1, F3_WORD, req_imm[4:0], OP_SW};
            end
            K_BEQ: begin
                imm_bad = !beq_ok;
                enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, F3_BEQ,
                       req_imm[4:1], req_imm[11], OP_BR};
            end
            K_JAL: begin
                imm_bad = !jal_ok;
                enc = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            end
            K_NOP:   enc = NOP_WORD;
            default: kind_bad = 1'b1;
        endcase
    end

    always_comb begin
        chk_code = 2'd0;
        if (kind_bad)     chk_code = 2'd1;
        else if (imm_bad) chk_code = 2'd2;
        else if (full)    chk_code = 2'd3;
    end

    assign new_err = chk && (chk_code != 2'd0);
    assign wr_en   = fire && !kind_bad && !imm_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            wr_cnt     <= '0;
            wr_vld     <= 1'b0;
            wr_q       <= '{addr: BASE_ADDR, dat: 32'h0};
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            wr_vld <= wr_en;
            if (wr_en) begin
                wr_q.addr <= BASE_ADDR + (XLEN'(wr_ptr) << 2);
                wr_q.dat  <= enc;
            end
            if (start) begin
                // A write already registered still goes out this cycle, but belongs to the old session.
                state      <= S_LOAD;
                wr_ptr     <= '0;
                wr_cnt     <= '0;
                err_q      <= 1'b0;
                err_code_q <= 2'd0;
            end else begin
                if (wr_vld) wr_cnt <= wr_cnt + CW'(1);
                if (wr_en)  wr_ptr <= wr_ptr + CW'(1);
                if (new_err) begin
                    state      <= S_ERR;
                    err_q      <= 1'b1;
                    err_code_q <= chk_code;
                end else begin
                    case (state)
                        S_IDLE:  state <= S_IDLE;
                        S_LOAD:  if (finish) state <= S_FLUSH;
                        S_FLUSH: state <= S_DONE;
                        S_DONE:  state <= S_DONE;
                        S_ERR:   state <= S_ERR;
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign imem_we    = wr_vld;
    assign imem_addr  = wr_q.addr;
    assign imem_wdata = wr_q.dat;
    assign busy       = (state == S_LOAD) || (state == S_FLUSH);
    assign done       = (state == S_DONE);
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign count      = wr_cnt;

endmodule
